// File: rtl/carry_skip_adder.sv
// Unsigned carry-skip adder: ripple carry inside each block, a skip mux on each block's carry-out,
// and a registered {cout, sum}.
module carry_skip_adder #(
    parameter int WIDTH = 4,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = (BLOCK >= 1) ? (WIDTH / BLOCK) : 1;

    generate
        if (WIDTH < 1 || BLOCK < 1 || ((BLOCK >= 1) ? (WIDTH % BLOCK) : 1) != 0) begin : g_bad_params
            $error("carry_skip_adder: WIDTH must be >= 1 and an integer multiple of BLOCK (>= 1)");
        end
    endgenerate

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;

    assign p = a ^ b;
    assign g = a & b;

    // Stage 0: combinational core. Inside a block the carry ripples bit by bit.
    // When every bit of the block propagates, the block carry-in bypasses the ripple chain.
    always_comb begin
        logic blk_carry;
        logic blk_cin;
        logic rip;
        logic bp;
        sum_d     = '0;
        blk_carry = cin;
        blk_cin   = 1'b0;
        rip       = 1'b0;
        bp        = 1'b1;
        for (int k = 0; k < NBLK; k++) begin
            blk_cin = blk_carry;
            rip     = blk_carry;
            bp      = 1'b1;
            for (int j = 0; j < BLOCK; j++) begin
                sum_d[k*BLOCK + j] = p[k*BLOCK + j] ^ rip;
                rip                = g[k*BLOCK + j] | (p[k*BLOCK + j] & rip);
                bp                 = bp & p[k*BLOCK + j];
            end
            blk_carry = bp ? blk_cin : rip;
        end
        cout_d = blk_carry;
    end

    // Stage 1: output register, loaded every cycle outside reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
        end else begin
            sum_p1  <= sum_d;
            cout_p1 <= cout_d;
        end
    end

    assign sum  = sum_p1;
    assign cout = cout_p1;

endmodule

// File: tb/tb_carry_skip_adder.sv
// Directed and exhaustive bench for carry_skip_adder: a 4-bit single-block build and an 8-bit two-block build.
module tb_carry_skip_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic [7:0] sum8;
    logic       cout8;

    int checks;
    int failures;

    carry_skip_adder #(.WIDTH(4), .BLOCK(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    carry_skip_adder #(.WIDTH(8), .BLOCK(4)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .sum  (sum8),
        .cout (cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one 4-bit vector between edges, then sample just after the next rising edge.
    task automatic vec4(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic vc, input logic [4:0] exp);
        @(negedge clk);
        a = va; b = vb; cin = vc;
        @(posedge clk);
        #1;
        check(tag, {27'd0, cout, sum}, {27'd0, exp});
    endtask

    task automatic vec8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [8:0] exp);
        @(negedge clk);
        a8 = va; b8 = vb; cin8 = vc;
        @(posedge clk);
        #1;
        check(tag, {23'd0, cout8, sum8}, {23'd0, exp});
    endtask

    logic [3:0] sa [8];
    logic [3:0] sb [8];
    logic       sc [8];
    logic [4:0] prev_exp;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        a = 4'hF; b = 4'hF; cin = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;

        // Reset held across several edges with the worst-case operands applied
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold4", {27'd0, cout, sum}, 32'd0);
            check("rst_hold8", {23'd0, cout8, sum8}, 32'd0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;

        vec4("v9p6c0", 4'd9, 4'd6, 1'b0, {1'b0, 4'd15});
        vec4("v6p6c1", 4'd6, 4'd6, 1'b1, {1'b0, 4'd13});
        vec4("v9p10c0", 4'd9, 4'd10, 1'b0, {1'b1, 4'd3});
        vec4("v6p9c1", 4'd6, 4'd9, 1'b1, {1'b1, 4'd0});
        vec4("skip5p10c0", 4'd5, 4'd10, 1'b0, {1'b0, 4'd15});
        vec4("skip5p10c1", 4'd5, 4'd10, 1'b1, {1'b1, 4'd0});
        vec4("v0p0c0", 4'd0, 4'd0, 1'b0, {1'b0, 4'd0});
        vec4("vFpFc1", 4'hF, 4'hF, 1'b1, {1'b1, 4'hF});

        vec8("m0Fp F0c1", 8'h0F, 8'hF0, 1'b1, {1'b1, 8'h00});
        vec8("m0Fp01c0", 8'h0F, 8'h01, 1'b0, {1'b0, 8'h10});
        vec8("mFFp01c0", 8'hFF, 8'h01, 1'b0, {1'b1, 8'h00});
        vec8("m80p80c1", 8'h80, 8'h80, 1'b1, {1'b1, 8'h01});
        vec8("m0Fp F0c0", 8'h0F, 8'hF0, 1'b0, {1'b0, 8'hFF});

        // Asynchronous reset in the middle of a cycle
        vec4("pre_async", 4'd9, 4'd6, 1'b0, {1'b0, 4'd15});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst4", {27'd0, cout, sum}, 32'd0);
        check("async_rst8", {23'd0, cout8, sum8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_first", {27'd0, cout, sum}, {27'd0, 5'd15});

        // Back-to-back stream; between edges the output still holds the previous vector's result
        for (int i = 0; i < 8; i++) begin
            sa[i] = 4'($urandom_range(15));
            sb[i] = 4'($urandom_range(15));
            sc[i] = 1'($urandom_range(1));
        end
        prev_exp = 5'd15;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("stream_hold", {27'd0, cout, sum}, {27'd0, prev_exp});
            a = sa[i]; b = sb[i]; cin = sc[i];
            @(posedge clk);
            #1;
            prev_exp = {1'b0, sa[i]} + {1'b0, sb[i]} + {4'd0, sc[i]};
            check("stream", {27'd0, cout, sum}, {27'd0, prev_exp});
        end

        // Exhaustive sweep of the 4-bit build
        for (int i = 0; i < 512; i++) begin
            logic [8:0] idx;
            logic [4:0] e;
            idx = 9'(i);
            e = {1'b0, idx[3:0]} + {1'b0, idx[7:4]} + {4'd0, idx[8]};
            vec4("exh", idx[3:0], idx[7:4], idx[8], e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carry_skip_adder.md
Name: carry_skip_adder

Overview:
- Unsigned binary adder built as a carry-skip (carry-bypass) structure, with registered outputs.
- Adds operands a and b plus a carry-in. Produces a WIDTH-bit sum and a carry-out.
- Used as a datapath arithmetic leaf. The default build is 4 bits with one skip block.
- One clock domain; outputs are registered for timing closure.

Parameters:
- WIDTH, 4, operand and sum width in bits. Must be ≥1 and an integer multiple of BLOCK.
- BLOCK, 4, bits per carry-skip block. Must be ≥1. Default gives a single block equal to WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in into bit 0.
- sum  output  WIDTH  registered sum bits, (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset:
  - While rst_n=0, sum=0 and cout=0 immediately, independent of clk.
  - Deassertion is sampled on the next rising clk edge.
- Latency:
  - Exactly 1 cycle. Inputs are sampled at rising edge N; the result is visible on sum/cout after edge N.
  - There is no input register stage.
  - A new operand set is accepted every cycle; throughput is 1 per clock.
  - There is no handshake: the output register loads every cycle when not in reset.
- Combinational core, per bit i:
  - Propagate p[i]=a[i]^b[i]; generate g[i]=a[i]&b[i].
  - Sum bit s[i]=p[i]^c[i]; c[0]=cin.
- Blocks:
  - The operand is split into WIDTH/BLOCK blocks of BLOCK bits, from the LSB upward.
  - Within a block, carry ripples: c[i+1]=g[i] | (p[i]&c[i]).
  - Block propagate BP = AND of p[] over the block's bits.
  - Block carry-out = BP ? block_cin : ripple carry out of the block's MSB.
  - This skip mux is the required structure, not a pure ripple or a lookahead adder.
  - Block k's carry-in is block k-1's carry-out; block 0's carry-in is cin.
- Outputs:
  - cout is the last block's carry-out.
  - The registered {cout,sum} must equal a+b+cin computed in WIDTH+1 bits, for all inputs.
- Boundary cases:
  - Full-propagate case (a^b all ones): cout=cin and sum=~cin replicated (all ones if cin=0, all zeros if cin=1). The skip path is exercised.
  - Overflow wraps modulo 2^WIDTH; there is no saturation and no signed interpretation.
- Reset mid-operation: the in-flight result is discarded and the outputs are forced to 0.
  - First valid output is one edge after rst_n rises, from inputs sampled at that edge.
- X/unknown inputs are not handled specially.
- Elaboration:
  - Illegal parameters (WIDTH not a multiple of BLOCK, or either value <1) must stop elaboration with an error.

Test Plan:
- Reset: hold rst_n=0 with a=4'hF, b=4'hF, cin=1 and toggle clk -> sum=0, cout=0 throughout; assert rst_n=0 asynchronously mid-cycle -> outputs go to 0 at once.
- Default WIDTH=4, rst_n=1; apply one vector per cycle, each checked one cycle later:
  - a=9, b=6, cin=0 -> sum=15, cout=0.
  - a=6, b=6, cin=1 -> sum=13, cout=0.
  - a=9, b=10, cin=0 -> sum=3, cout=1.
  - a=6, b=9, cin=1 -> sum=0, cout=1 (full-propagate skip path).
- Skip path, WIDTH=4: a=5, b=10, cin=0 -> sum=15, cout=0; same operands with cin=1 -> sum=0, cout=1.
- Multi-block, WIDTH=8, BLOCK=4:
  - a=8'h0F, b=8'hF0, cin=1 -> sum=8'h00, cout=1 (both blocks skip).
  - a=8'h0F, b=8'h01, cin=0 -> sum=8'h10, cout=0 (carry crosses the block boundary via ripple).
- Back-to-back throughput: stream 8 consecutive random vectors without gaps -> each output matches a+b+cin of the vector applied exactly one cycle earlier.
- Exhaustive, WIDTH=4: all 512 combinations of a, b and cin, compared against a behavioural a+b+cin with 1-cycle delay; zero mismatches.
